// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame-level read/write sequencer for the 3x3 convolution filter
//
// Walks the frame-buffer read port over every pixel and then re-reads the first
// IMAGE_WIDTH+1 pixels so the filter's row delay and pipeline drain the tail of
// the frame. A tag pipe that matches the filter latency marks which filter
// outputs are real, and where each one belongs in the output buffer.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (deassertion synchronised)
//   start          frame request pulse, honoured only while idle
//   rd_grant       shared read port granted this cycle
//   rd_address     frame-buffer / filter read address
//   rd_valid       read issued this cycle
//   filt_data      filter output
//   wr_address     output-buffer write address (centre pixel)
//   wr_data        filtered pixel, zero when wr_en is low
//   wr_en          output-buffer write strobe
//   busy           high whenever not idle
//   done           one-cycle frame completion pulse
//   stall_cycles   denied-read cycle count (only when CONV_SEQ_PERF_EN is defined)
module conv_frame_sequencer #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int PIXEL_BITS   = 12,
   parameter int PIPE_LATENCY = 6,
   parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  rd_grant,
   output logic [ADDR_BITS-1:0]  rd_address,
   output logic                  rd_valid,
   input  logic [PIXEL_BITS-1:0] filt_data,
   output logic [ADDR_BITS-1:0]  wr_address,
   output logic [PIXEL_BITS-1:0] wr_data,
   output logic                  wr_en,
   output logic                  busy,
   output logic                  done
`ifdef CONV_SEQ_PERF_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   localparam int VW     = ADDR_BITS + 1;
   localparam int N      = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int OFFSET = IMAGE_WIDTH + 1;

   localparam logic [VW-1:0] N_V        = VW'(N);
   localparam logic [VW-1:0] OFF_V      = VW'(OFFSET);
   localparam logic [VW-1:0] RUN_LAST   = VW'(N - 1);
   localparam logic [VW-1:0] DRAIN_LAST = VW'(N + OFFSET - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // Reset asserts immediately but releases two clocks after rst_n rises.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

   logic [VW-1:0]           vaddr;
   logic                    issuing;
   logic                    accept;
   logic [PIPE_LATENCY-1:0] pipe_v;
   logic [VW-1:0]           pipe_a [PIPE_LATENCY];
   logic [PIPE_LATENCY-1:0] pipe_upstream;
   logic [VW-1:0]           tail_a;

   assign issuing  = (state == S_RUN) || (state == S_DRAIN);
   assign rd_valid = issuing && rd_grant;
   assign accept   = (state == S_IDLE) && start;

   // Addresses past the frame wrap onto the first OFFSET pixels to push the tail through.
   assign rd_address = ADDR_BITS'((vaddr < N_V) ? vaddr : (vaddr - N_V));

   // Every stage except the tail is empty: the last tagged result leaves this cycle.
   assign pipe_upstream = pipe_v << 1;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (rd_valid && (vaddr == RUN_LAST)) state_nxt = S_DRAIN;
         S_DRAIN: if (rd_valid && (vaddr == DRAIN_LAST)) state_nxt = S_FLUSH;
         S_FLUSH: if (pipe_upstream == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)    vaddr <= '0;
      else if (accept)   vaddr <= '0;
      else if (rd_valid) vaddr <= vaddr + VW'(1);
   end

   // Tag pipe shifts every cycle so denied reads show up as write gaps downstream.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pipe_v <= '0;
         for (int i = 0; i < PIPE_LATENCY; i++) pipe_a[i] <= '0;
      end else begin
         pipe_v[0] <= rd_valid;
         pipe_a[0] <= vaddr;
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end

   assign tail_a = pipe_a[PIPE_LATENCY-1];

   // The first OFFSET results are still filling the row delay and are discarded.
   assign wr_en      = pipe_v[PIPE_LATENCY-1] && (tail_a >= OFF_V);
   assign wr_address = wr_en ? ADDR_BITS'(tail_a - OFF_V) : '0;
   assign wr_data    = wr_en ? filt_data : '0;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

`ifdef CONV_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)
         stall_cycles <= '0;
      else if (accept)
         stall_cycles <= '0;
      else if (issuing && !rd_grant && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - directed and randomized bench for conv_frame_sequencer
module tb_conv_frame_sequencer;

   localparam int W   = 4;
   localparam int H   = 3;
   localparam int L   = 6;
   localparam int PB  = 12;
   localparam int AB  = 4;
   localparam int N   = W * H;
   localparam int OFF = W + 1;
   localparam int NV  = N + OFF;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          rd_grant;
   logic [AB-1:0] rd_address;
   logic          rd_valid;
   logic [PB-1:0] filt_data;
   logic [AB-1:0] wr_address;
   logic [PB-1:0] wr_data;
   logic          wr_en;
   logic          busy;
   logic          done;
`ifdef CONV_SEQ_PERF_EN
   logic [31:0]   stall_cycles;
`endif

   conv_frame_sequencer #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .PIXEL_BITS  (PB),
      .PIPE_LATENCY(L)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .rd_grant    (rd_grant),
      .rd_address  (rd_address),
      .rd_valid    (rd_valid),
      .filt_data   (filt_data),
      .wr_address  (wr_address),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .busy        (busy),
      .done        (done)
`ifdef CONV_SEQ_PERF_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int c;
      int a;
   } wr_t;

   int          n_cmp;
   int          n_bad;
   int          cyc;
   logic        rst_lvl;
   int          rst_cnt;
   logic [PB-1:0] mem [N];
   int          dly [L];
   int          last_rd;

   // Reference model: a frame is NV reads; read k (k >= OFF) yields a write to k-OFF, L cycles on.
   logic        m_active;
   int          m_k;
   int          m_done_cyc;
   logic [31:0] m_stall;
   wr_t         wq [$];

   int acc_cyc;
   int frame_wr;
   int frame_done;
   int first_wr;
   int last_wr;
   int done_seen;
   int gap;
   logic gr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_address"}, 32'(rd_address), 32'd0);
      chk({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
      chk({tag, "_wr_address"}, 32'(wr_address), 32'd0);
      chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
      chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_done"},       32'(done),       32'd0);
`ifdef CONV_SEQ_PERF_EN
      chk({tag, "_stall"},      stall_cycles,    32'd0);
`endif
   endtask

   task automatic model_reset();
      m_active   = 1'b0;
      m_k        = 0;
      m_done_cyc = -1;
      m_stall    = '0;
      rst_cnt    = 0;
      wq.delete();
   endtask

   // One clock: drive inputs just after the rising edge, check outputs at the falling edge.
   task automatic cycle(input logic st, input logic g);
      logic run, e_rdv, e_wr, e_done, accept;
      int   ea;
      @(posedge clk);
      #1;
      for (int i = L - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0]    = last_rd;
      filt_data = mem[dly[L-1]];
      rst_n     = rst_lvl;
      start     = st;
      rd_grant  = g;
      @(negedge clk);

      run    = m_active && (m_k < NV);
      e_rdv  = run && g;
      e_wr   = (wq.size() > 0) && (wq[0].c == cyc);
      e_done = m_active && (cyc == m_done_cyc);

      chk("busy",     32'(busy),     32'(m_active));
      chk("done",     32'(done),     32'(e_done));
      chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
      if (run) chk("rd_address", 32'(rd_address), 32'((m_k < N) ? m_k : m_k - N));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr) begin
         ea = wq[0].a;
         chk("wr_address", 32'(wr_address), 32'(ea));
         chk("wr_data",    32'(wr_data),    32'(mem[(ea + OFF) % N]));
      end
`ifdef CONV_SEQ_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif

      last_rd = int'(rd_address);
      if (wr_en) begin
         frame_wr++;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
      end
      if (done) begin
         frame_done++;
         done_seen = cyc;
      end

      accept = !m_active && st && rst_lvl && (rst_cnt >= 2);
      if (accept) m_stall = '0;
      else if (run && !g) m_stall = m_stall + 32'd1;
      if (e_wr) void'(wq.pop_front());
      if (e_rdv) begin
         if (m_k >= OFF) wq.push_back('{cyc + L, m_k - OFF});
         if (m_k == NV - 1) m_done_cyc = cyc + L + 1;
         m_k++;
      end
      if (e_done) m_active = 1'b0;
      if (accept) begin
         m_active   = 1'b1;
         m_k        = 0;
         m_done_cyc = -1;
         acc_cyc    = cyc;
         frame_wr   = 0;
         frame_done = 0;
         first_wr   = -1;
         last_wr    = -1;
         done_seen  = -1;
      end
      if (rst_lvl) rst_cnt++;
      else         rst_cnt = 0;
      cyc++;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; last_rd = 0;
      acc_cyc = -1; frame_wr = 0; frame_done = 0; first_wr = -1; last_wr = -1; done_seen = -1;
      rst_lvl = 1'b0; rst_n = 1'b0; start = 1'b0; rd_grant = 1'b0; filt_data = '0;
      for (int i = 0; i < L; i++) dly[i] = 0;
      for (int i = 0; i < N; i++) mem[i] = PB'($urandom);
      model_reset();

      // Power-on reset, then release; start is honoured two cycles after rst_n rises.
      repeat (3) cycle(1'b0, 1'b0);
      chk_zero("por");
      rst_lvl = 1'b1;
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);

      // Frame A: continuous grant.
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 100 && done_seen < 0; i++) cycle(1'b0, 1'b1);
      chk("a_first_wr_after_run", 32'(first_wr - acc_cyc - 1), 32'd11);
      chk("a_start_to_done",      32'(done_seen - acc_cyc + 1), 32'd25);
      chk("a_writes",             32'(frame_wr), 32'd12);
      repeat (2) cycle(1'b0, 1'b1);

      // Frame B: three denied cycles while vaddr sits at 7.
      cycle(1'b1, 1'b1);
      gap = 3;
      for (int i = 0; i < 100 && done_seen < 0; i++) begin
         gr = !((m_k == 7) && (gap > 0));
         if (!gr) gap--;
         cycle(1'b0, gr);
      end
      chk("b_start_to_done", 32'(done_seen - acc_cyc + 1), 32'd28);
      chk("b_writes",        32'(frame_wr), 32'd12);
      chk("b_write_span",    32'(last_wr - first_wr + 1), 32'd15);
`ifdef CONV_SEQ_PERF_EN
      chk("b_stall_cycles",  stall_cycles, 32'd3);
`endif
      cycle(1'b0, 1'b1);

      // Frame C: start held high through every state, random grant, including the done cycle.
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 200 && done_seen < 0; i++) cycle(1'b1, 1'($urandom_range(0, 3) != 0));
      chk("c_writes",      32'(frame_wr), 32'd12);
      chk("c_done_pulses", 32'(frame_done), 32'd1);

      // Frame D: start one cycle after done begins at vaddr 0; reset lands in DRAIN.
      cycle(1'b1, 1'b1);
      chk("d_accepted_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 100 && m_k < N + 2; i++) cycle(1'b0, 1'b1);
      chk("d_in_drain_busy", 32'(busy), 32'd1);
      #2;
      rst_lvl = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk_zero("mid_rst");
      model_reset();
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      rst_lvl = 1'b1;
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);

      // Frame E: normal completion after the mid-frame reset, random grant.
      for (int i = 0; i < 200 && (done_seen < 0 || frame_done == 0); i++) cycle(1'b0, 1'($urandom_range(0, 3) != 0));
      chk("e_writes",      32'(frame_wr), 32'd12);
      chk("e_done_pulses", 32'(frame_done), 32'd1);
      repeat (3) cycle(1'b0, 1'b1);
      chk("end_idle_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the 3x3 convolution filter. On `start` it walks the frame buffer read port across every pixel, presents addresses to the filter, and tags the filter's fixed-latency output so each filtered pixel is written to the output buffer exactly once at its centre-pixel address. It pauses when the shared frame-buffer read port is not granted, then flushes the filter's row delay and pipeline before signalling `done`.

## Interface
- `IMAGE_WIDTH`, 320, pixels per row
- `IMAGE_HEIGHT`, 240, rows per frame
- `PIXEL_BITS`, 12, bits per pixel (RGB444)
- `PIPE_LATENCY`, 6, cycles from a read address being issued to the filter producing the corresponding result
- `ADDR_BITS`, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), address width
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  frame request pulse; ignored unless IDLE
- `rd_grant`  in  1  shared read port granted to this block this cycle
- `rd_address`  out  ADDR_BITS  frame-buffer read address, which also drives the filter
- `rd_valid`  out  1  an address is issued this cycle
- `filt_data`  in  PIXEL_BITS  filter output
- `wr_address`  out  ADDR_BITS  output-buffer write address
- `wr_data`  out  PIXEL_BITS  equals `filt_data` when `wr_en` is high
- `wr_en`  out  1  write strobe
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- N = IMAGE_WIDTH*IMAGE_HEIGHT. OFFSET = IMAGE_WIDTH+1, the filter's centre-pixel lag.
- A virtual counter `vaddr` is ADDR_BITS+1 bits wide and counts 0..N+OFFSET-1.
- `rd_address` = `vaddr` when `vaddr` < N, otherwise `vaddr`-N. The wrap re-reads pixels 0..OFFSET-1 to push the tail of the frame through the filter.
- States:
  - IDLE: waits for `start`, then clears `vaddr` and moves to RUN.
  - RUN: issues reads while `vaddr` < N. Moves to DRAIN after issuing N-1.
  - DRAIN: issues reads while `vaddr` < N+OFFSET. Moves to FLUSH after issuing N+OFFSET-1.
  - FLUSH: waits until the tag pipe is empty, then moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- In RUN and DRAIN: `rd_valid` = `rd_grant`. `vaddr` increments only when `rd_valid` is high. When `rd_grant` is low, `rd_address` holds its value.
- The tag pipe is PIPE_LATENCY deep and carries {valid, `vaddr`}. It shifts every cycle regardless of grant. `rd_valid` and `vaddr` enter at the head.
- `wr_en` = tail.valid AND tail.`vaddr` >= OFFSET. `wr_address` = tail.`vaddr` - OFFSET.
- Each frame produces exactly N writes, to addresses 0..N-1, each written once, in ascending order.
- The subtraction is done at ADDR_BITS+1 width, and the result is truncated only after the range check.
- `start` in any state other than IDLE is ignored. There is no abort; `rst_n` is the only way to terminate a frame.
- Reset values: `rd_address` 0, `rd_valid` 0, `wr_address` 0, `wr_data` 0, `wr_en` 0, `busy` 0, `done` 0, state IDLE, tag pipe all invalid.
- Reset mid-frame clears all state immediately. No write may occur after reset deasserts until a new `start`.

## Timing
- Reset deassertion is synchronised inside the block. The first `start` is accepted 2 cycles after `rst_n` rises.
- `start` is sampled at edge k. In the cycle after edge k, the block is in RUN and `busy` is 1. `rd_valid` is high that cycle if `rd_grant` is high.
- Each issued address produces its tagged write exactly PIPE_LATENCY cycles later.
- With continuous grant, the first `wr_en` occurs PIPE_LATENCY+OFFSET cycles after RUN is entered.
- `done` is high in the cycle after the last `wr_en`.
- With continuous grant, `start` to `done` takes N+OFFSET+PIPE_LATENCY+2 cycles.
- `busy` falls in the cycle after `done`.
- When `rd_grant` is low, write gaps appear PIPE_LATENCY cycles later. Total frame time grows by exactly the number of denied cycles in RUN and DRAIN.

## Configuration
- `CONV_SEQ_PERF_EN` defined: adds output `stall_cycles` [31:0].
  - Counts cycles spent in RUN or DRAIN with `rd_grant` low.
  - Saturates at 2^32-1.
  - Cleared when `start` is accepted. Holds its value after `done`.
  - Resets to 0.
- `CONV_SEQ_PERF_EN` undefined: the port and the counter do not exist. All other behaviour is identical.

## Test plan
The bench uses IMAGE_WIDTH=4, IMAGE_HEIGHT=3, PIPE_LATENCY=6, so N=12 and OFFSET=5.
- Continuous grant, `start` pulse:
  - `rd_address` sequence is 0..11 then 0..4.
  - `wr_en` fires 12 times at addresses 0..11, the first one 11 cycles after RUN is entered.
  - `done` arrives exactly 25 cycles after the `start` edge.
- `rd_grant` low for 3 cycles at `vaddr`=7:
  - `rd_address` holds at 7.
  - Three write gaps appear 6 cycles later.
  - `done` is delayed by exactly 3 cycles.
  - `stall_cycles`=3 when the macro is defined.
- `start` asserted in RUN, DRAIN and FLUSH: no effect, still exactly 12 writes and one `done`.
- `rst_n` pulsed low mid-DRAIN:
  - All outputs are 0 at once.
  - No `wr_en` before the next `start`.
  - The next frame completes normally with 12 writes.
- Back-to-back frames, with `start` asserted in the cycle `done` is high: the second `start` is ignored. A `start` one cycle later begins the next frame with `vaddr`=0.
- Scoreboard check: `filt_data` driven as a model of the filter, i.e. `rd_address` delayed 6 cycles. Every `wr_data` must equal the pixel read OFFSET issues earlier.
